// File: rtl/acc_requant_writer.sv
// Requantizing output writer: buffers accumulator vectors, scales/rounds/saturates each lane,
// and writes packed words to the output buffer under a job-level IDLE/RUN/DONE FSM.
module acc_requant_writer #(
    parameter int unsigned TILE_SIZE   = 4,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned SCALE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [SCALE_WIDTH-1:0]              cfg_scale,
    input  logic [5:0]                          cfg_shift,
    input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]               cfg_num_vec,
    input  logic                                valid_in,
    input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] vec_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic [TILE_SIZE*OUT_WIDTH-1:0]      out_data,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow_err,
    output logic [15:0]                         sat_count
);
    localparam int unsigned PW  = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW  = $clog2(TILE_SIZE + 1);
    localparam logic signed [PW:0] SatHi = (PW+1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [PW:0] SatLo = ~SatHi;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [SCALE_WIDTH-1:0]  scale_q;
    logic [5:0]              shift_q;
    logic [ADDR_WIDTH-1:0]   num_vec_q, count_q;

    logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FAW:0]            wptr_q, rptr_q;
    logic                    m_valid_q, r_valid_q, o_valid_q;
    logic signed [PW-1:0]    m_prod_q [TILE_SIZE];
    logic signed [PW-1:0]    prod_c [TILE_SIZE];
    logic [TILE_SIZE*OUT_WIDTH-1:0] r_data_q, rq_c;
    logic [TILE_SIZE-1:0]    r_sat_q, sat_c;
    logic signed [PW:0]      ext_c, half_c, rnd_c;
    logic [SW-1:0]           sat_sum;
    logic [16:0]             sat_next;

    logic empty, full, hs, o_load, r_load, pop, push_req, push, drop, flush, accept;
    logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] head;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
    assign head     = mem[rptr_q[FAW-1:0]];
    assign hs       = o_valid_q && out_ready;
    // Each stage advances when the stage ahead is empty or advancing, so bubbles collapse.
    assign o_load   = r_valid_q && (!o_valid_q || out_ready);
    assign r_load   = m_valid_q && (!r_valid_q || o_load);
    assign pop      = !empty && (!m_valid_q || r_load);
    assign push_req = valid_in && (state_q == StRun);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign flush    = (state_d != StRun);
    assign accept   = (state_q == StIdle) && start && (cfg_num_vec != '0);

    assign out_valid = o_valid_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = (cfg_num_vec != '0) ? StRun : StDone;
            StRun:  if (hs && (ADDR_WIDTH'(count_q + 1'b1) == num_vec_q)) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int j = 0; j < TILE_SIZE; j++) begin
            prod_c[j] = PW'($signed(head[j])) * PW'($signed({1'b0, scale_q}));
        end
    end

    // Round half up: add 2^(shift-1) before the arithmetic shift, then clamp.
    always_comb begin
        rq_c   = '0;
        sat_c  = '0;
        ext_c  = '0;
        half_c = '0;
        rnd_c  = '0;
        for (int j = 0; j < TILE_SIZE; j++) begin
            ext_c  = {m_prod_q[j][PW-1], m_prod_q[j]};
            half_c = '0;
            if (shift_q != 6'd0) half_c = (PW+1)'(1) << (shift_q - 6'd1);
            rnd_c = (ext_c + half_c) >>> shift_q;
            if (rnd_c > SatHi) begin
                rq_c[j*OUT_WIDTH +: OUT_WIDTH] = SatHi[OUT_WIDTH-1:0];
                sat_c[j] = 1'b1;
            end else if (rnd_c < SatLo) begin
                rq_c[j*OUT_WIDTH +: OUT_WIDTH] = SatLo[OUT_WIDTH-1:0];
                sat_c[j] = 1'b1;
            end else begin
                rq_c[j*OUT_WIDTH +: OUT_WIDTH] = rnd_c[OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sat_sum = '0;
        for (int j = 0; j < TILE_SIZE; j++) sat_sum = sat_sum + SW'(r_sat_q[j]);
        sat_next = {1'b0, sat_count} + 17'(sat_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            scale_q      <= '0;
            shift_q      <= '0;
            num_vec_q    <= '0;
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            m_valid_q    <= 1'b0;
            r_valid_q    <= 1'b0;
            o_valid_q    <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
            overflow_err <= 1'b0;
            sat_count    <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wptr_q    <= '0;
                rptr_q    <= '0;
                m_valid_q <= 1'b0;
                r_valid_q <= 1'b0;
                o_valid_q <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                m_valid_q <= pop || (m_valid_q && !r_load);
                r_valid_q <= r_load || (r_valid_q && !o_load);
                o_valid_q <= o_load || (o_valid_q && !out_ready);
            end
            if (o_load) out_data <= r_data_q;
            if (accept) begin
                scale_q      <= cfg_scale;
                shift_q      <= cfg_shift;
                num_vec_q    <= cfg_num_vec;
                count_q      <= '0;
                out_addr     <= cfg_base_addr;
                overflow_err <= 1'b0;
                sat_count    <= '0;
            end else begin
                if (hs) begin
                    out_addr <= out_addr + 1'b1;
                    count_q  <= count_q + 1'b1;
                end
                if (drop) overflow_err <= 1'b1;
                if (o_load && !flush) sat_count <= sat_next[16] ? 16'hFFFF : sat_next[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[FAW-1:0]] <= vec_in;
        if (pop) begin
            for (int j = 0; j < TILE_SIZE; j++) m_prod_q[j] <= prod_c[j];
        end
        if (r_load) begin
            r_data_q <= rq_c;
            r_sat_q  <= sat_c;
        end
    end

endmodule

// File: tb/tb_acc_requant_writer.sv
// Directed bench for acc_requant_writer: latency, rounding, saturation, backpressure/overflow,
// address wrap, zero-length jobs and mid-job reset, with hand-computed expectations.
module tb_acc_requant_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_scale = '0;
    logic [5:0]  cfg_shift = '0;
    logic [9:0]  cfg_base_addr = '0;
    logic [9:0]  cfg_num_vec = '0;
    logic        valid_in = 1'b0;
    logic [3:0][31:0] vec_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_addr;
    logic [31:0] out_data;
    logic        busy, done, overflow_err;
    logic [15:0] sat_count;

    int vectors = 0;
    int miscompares = 0;

    acc_requant_writer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .cfg_base_addr(cfg_base_addr), .cfg_num_vec(cfg_num_vec), .valid_in(valid_in),
        .vec_in(vec_in), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done), .overflow_err(overflow_err),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d);
        vec_in[0] = a; vec_in[1] = b; vec_in[2] = c; vec_in[3] = d;
    endtask

    task automatic do_start(input int scale, input int shift, input int base, input int num);
        cfg_scale = 16'(scale); cfg_shift = 6'(shift);
        cfg_base_addr = 10'(base); cfg_num_vec = 10'(num);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input int a, input int b, input int c, input int d);
        set_vec(a, b, c, d);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({out_valid, busy, done, overflow_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0000", {out_valid, busy, done, overflow_err});
        end
        vectors++;
        if (out_addr !== 10'h000 || out_data !== 32'h0 || sat_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs got addr=%h data=%h sat=%h want 0", out_addr, out_data,
                     sat_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        do_start(1, 0, 'h010, 1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_busy got %b want 1", busy);
        end
        send_vec(5, -3, 127, -128);
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_latency_early got %b want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_latency got %b want 1", out_valid);
        end
        vectors++;
        if (out_data !== 32'h807FFD05 || out_addr !== 10'h010) begin
            miscompares++;
            $display("FAIL basic_word got data=%h addr=%h want 807ffd05 010", out_data, out_addr);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done got done=%b valid=%b want 1 0", done, out_valid);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_idle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_rounding();
        bit ok;
        out_ready = 1'b1;
        do_start(3, 2, 'h040, 1);
        send_vec(1, -1, 5, -5);
        wait_out(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL round_timeout got none want out_valid"); end
        vectors++;
        if (out_data !== 32'hFC04FF01 || out_addr !== 10'h040 || sat_count !== 16'd0) begin
            miscompares++;
            $display("FAIL round_word got data=%h addr=%h sat=%0d want fc04ff01 040 0",
                     out_data, out_addr, sat_count);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL round_done got none want done"); end
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        out_ready = 1'b1;
        do_start(1000, 0, 'h050, 1);
        send_vec(1, -1, 0, 2);
        wait_out(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sat_timeout got none want out_valid"); end
        vectors++;
        if (out_data !== 32'h7F00807F) begin
            miscompares++; $display("FAIL sat_word got %h want 7f00807f", out_data);
        end
        vectors++;
        if (sat_count !== 16'd3) begin
            miscompares++; $display("FAIL sat_count got %0d want 3", sat_count);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sat_done got none want done"); end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        do_start(1, 0, 'h020, 8);
        valid_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            set_vec(k, 0, 0, 0);
            tick();
            if (k == 7) begin
                vectors++;
                if (overflow_err !== 1'b0) begin
                    miscompares++; $display("FAIL bp_no_overflow_7 got %b want 0", overflow_err);
                end
            end
        end
        valid_in = 1'b0;
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++; $display("FAIL bp_overflow_8 got %b want 1", overflow_err);
        end
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data[7:0] !== 8'd1 || out_addr !== 10'h020) begin
            miscompares++;
            $display("FAIL bp_stall_hold got v=%b lane0=%0d addr=%h want 1 1 020", out_valid,
                     out_data[7:0], out_addr);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data[7:0] !== 8'(k) || out_addr !== 10'(32 + k - 1))
            begin
                miscompares++;
                $display("FAIL bp_write_%0d got v=%b lane0=%0d addr=%h want 1 %0d %h", k,
                         out_valid, out_data[7:0], out_addr, k, 10'(32 + k - 1));
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_await_8th got v=%b busy=%b done=%b want 0 1 0", out_valid, busy,
                     done);
        end
        send_vec(9, 0, 0, 0);
        wait_out(ok);
        vectors++;
        if (!ok || out_data[7:0] !== 8'd9 || out_addr !== 10'h027) begin
            miscompares++;
            $display("FAIL bp_write_8 got ok=%b lane0=%0d addr=%h want 1 9 027", ok,
                     out_data[7:0], out_addr);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_done got none want done"); end
        tick();
    endtask

    task automatic test_addr_wrap();
        logic [9:0] addrs [3];
        int idx [3];
        int n = 0;
        int done_at = -1;
        out_ready = 1'b1;
        do_start(1, 0, 'h3FE, 3);
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++; $display("FAIL wrap_ovf_cleared got %b want 0", overflow_err);
        end
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_vec(10 + k, 0, 0, 0);
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && out_ready && n < 3) begin
                addrs[n] = out_addr; idx[n] = i; n++;
            end
            if (done && done_at < 0) done_at = i;
            tick();
        end
        vectors++;
        if (n !== 3) begin
            miscompares++; $display("FAIL wrap_count got %0d want 3", n);
        end else begin
            vectors++;
            if (addrs[0] !== 10'h3FE || addrs[1] !== 10'h3FF || addrs[2] !== 10'h000) begin
                miscompares++;
                $display("FAIL wrap_addrs got %h %h %h want 3fe 3ff 000", addrs[0], addrs[1],
                         addrs[2]);
            end
            vectors++;
            if (idx[2] - idx[0] !== 2 || done_at !== idx[2] + 1) begin
                miscompares++;
                $display("FAIL wrap_timing got span=%0d done_at=%0d want 2 %0d",
                         idx[2] - idx[0], done_at, idx[2] + 1);
            end
        end
    endtask

    task automatic test_zero_vec();
        int done_cnt = 0;
        int first_done = -1;
        bit saw_valid = 1'b0;
        bit saw_busy = 1'b0;
        cfg_num_vec = 10'd0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
            if (out_valid) saw_valid = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        vectors++;
        if (done_cnt !== 1 || first_done > 1 || first_done < 0) begin
            miscompares++;
            $display("FAIL zero_done got cnt=%0d first=%0d want 1 within 2 cycles", done_cnt,
                     first_done);
        end
        vectors++;
        if (saw_valid || saw_busy) begin
            miscompares++;
            $display("FAIL zero_no_write got valid=%b busy=%b want 0 0", saw_valid, saw_busy);
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        out_ready = 1'b0;
        do_start(1000, 0, 'h100, 2);
        send_vec(1, 1, 1, 1);
        wait_out(ok);
        vectors++;
        if (!ok || sat_count !== 16'd4) begin
            miscompares++;
            $display("FAIL rstmid_setup got ok=%b sat=%0d want 1 4", ok, sat_count);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_async got %b want 0", out_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || sat_count !== 16'd0 || out_valid !== 1'b0 || out_addr !== 10'h0)
        begin
            miscompares++;
            $display("FAIL rstmid_after got busy=%b sat=%0d v=%b addr=%h want 0 0 0 000", busy,
                     sat_count, out_valid, out_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_addr_wrap();
        test_zero_vec();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
